// File: rtl/data_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_responder_pkg
// Brief    : Shared bus types, responder state encoding and access constants.
// Revision : 1.0
// ============================================================================
package data_ram_responder_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 32;
    localparam int c_SEL_W  = 4;
    localparam int c_WAIT_W = 4;

    typedef logic [c_DATA_W-1:0] data_bus_t;
    typedef logic [c_ADDR_W-1:0] addr_bus_t;
    typedef logic [c_SEL_W-1:0]  sel_bus_t;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_ACK  = 2'd2
    } resp_state_t;

    localparam logic c_WRITE_ENABLE = 1'b1;
    localparam logic c_READ_ENABLE  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/data_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_responder_if
// Brief    : CPU data-memory port bundle between initiator and responder.
// Revision : 1.0
// ============================================================================
interface data_ram_responder_if;
    import data_ram_responder_pkg::*;

    logic      ce;
    logic      we;
    addr_bus_t addr;
    sel_bus_t  sel;
    data_bus_t data_i;
    data_bus_t data_o;
    logic      ack_o;
    logic      err_o;
    logic      stall_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, ack_o, err_o, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/data_ram_responder_sram_word_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_word_array
// Brief    : Word array with byte-lane synchronous write and asynchronous read.
// Revision : 1.0
// ============================================================================
module sram_word_array
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  wire logic             clock,
    input  wire logic             we,
    input  wire sel_bus_t         sel,
    input  wire logic [IDX_W-1:0] waddr,
    input  wire data_bus_t        wdata,
    input  wire logic [IDX_W-1:0] raddr,
    output data_bus_t             rdata
);

    // One narrow array per lane keeps the byte enables a plain per-array write.
    for (genvar g = 0; g < c_SEL_W; g++) begin : g_lane
        logic [7:0] r_lane [DEPTH_WORDS];

        always_ff @(posedge clock) begin
            if (we && sel[g]) begin
                r_lane[waddr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = r_lane[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_responder
// Brief    : Data-memory responder with programmable wait states and range error.
// Revision : 1.0
// ============================================================================
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  wire logic           clock,
    input  wire logic           reset,
    data_ram_responder_if.slave bus
);

    localparam int                c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0]       c_SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(WAIT_CYCLES);

    resp_state_t         r_state;
    resp_state_t         w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                w_capture;

    logic      r_we;
    addr_bus_t r_addr;
    sel_bus_t  r_sel;
    data_bus_t r_wdata;
    data_bus_t r_rdata_hold;

    addr_bus_t          w_offset;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_word_idx;
    data_bus_t          w_rdata;
    data_bus_t          w_read_word;
    logic               w_ack;
    logic               w_mem_we;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_in_range  = (w_offset < c_SPAN);
    assign w_word_idx  = w_offset[c_IDX_W+1:2];
    assign w_ack       = (r_state == RESP_ACK);
    assign w_read_word = w_in_range ? w_rdata : '0;
    assign w_mem_we    = w_ack && (r_we == c_WRITE_ENABLE) && w_in_range && !reset;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        case (r_state)
            RESP_IDLE: begin
                if (bus.ce) begin
                    w_capture      = 1'b1;
                    w_wait_cnt_nxt = c_WAIT_LOAD;
                    w_state_nxt    = (c_WAIT_LOAD == '0) ? RESP_ACK : RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                if (!bus.ce) begin
                    w_state_nxt    = RESP_IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                    if (r_wait_cnt == c_WAIT_W'(1)) begin
                        w_state_nxt = RESP_ACK;
                    end
                end
            end
            RESP_ACK: begin
                w_state_nxt = RESP_IDLE;
            end
            default: begin
                w_state_nxt    = RESP_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RESP_IDLE;
            r_wait_cnt   <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_ack && (r_we == c_READ_ENABLE)) begin
                r_rdata_hold <= w_read_word;
            end
        end
    end

    // Request fields are frozen at capture; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_sel   <= bus.sel;
            r_wdata <= bus.data_i;
        end
    end

    sram_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clock (clock),
        .we    (w_mem_we),
        .sel   (r_sel),
        .waddr (w_word_idx),
        .wdata (r_wdata),
        .raddr (w_word_idx),
        .rdata (w_rdata)
    );

    assign bus.ack_o   = w_ack;
    assign bus.err_o   = w_ack && !w_in_range;
    assign bus.data_o  = (w_ack && (r_we == c_READ_ENABLE)) ? w_read_word : r_rdata_hold;
    assign bus.stall_o = bus.ce && !w_ack;

endmodule
`default_nettype wire
